// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeding an LSB-first
// serialiser. Bytes are popped straight into the shift register, so a new
// frame follows a stop bit with no idle gap while data is queued.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RSTb,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          uart_tx
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam logic [CW-1:0] BAUD_LAST  = CW'(DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  // Reject parameter sets the datapath cannot represent.
  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q;
  logic          tx_q, tx_d;

  logic          push, pop, fifo_nonempty, baud_done;

  assign push          = wr_valid && ready_q;
  assign fifo_nonempty = (level_q != '0);
  assign baud_done     = (baud_q == BAUD_LAST);
  assign level_d       = level_q + LW'(push) - LW'(pop);

  // FIFO storage write port; no reset so it maps onto RAM.
  always_ff @(posedge CLK) begin
    if (RSTb && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO read port: the head byte is captured into the shift register on a pop.
  always_ff @(posedge CLK) begin
    if (pop) begin
      shift_q <= mem_q[rd_ptr_q];
    end
  end

  // FIFO pointers, occupancy and registered ready (low while full, and during reset).
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ready_q <= (level_d != LEVEL_FULL);
    end
  end

  // Serialiser state register, counters and registered line output.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic: every line state lasts DIV cycles; pops happen from IDLE or at stop expiry.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: line level for the state being entered, registered into tx_q.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign uart_tx    = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign wr_ready   = ready_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DIV=10, depth 4. A line monitor decodes frames
// independently from the pin; tasks compare against a queue of accepted bytes.
module tb_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       CLK = 1'b0;
  logic       RSTb = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic [2:0] fifo_level;
  logic       tx_busy;
  logic       uart_tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rst_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];
  bit         rx_ok[$];

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTb(RSTb), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .fifo_level(fifo_level), .tx_busy(tx_busy), .uart_tx(uart_tx)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RSTb === 1'b0) rst_cnt <= rst_cnt + 1;
  end

  // Line monitor: decodes 8N1 frames sampled at negedge; frames cut by reset are dropped.
  initial begin : monitor
    logic [9:0] seg;
    int t0, r0;
    bit ok, aborted;
    forever begin
      @(negedge CLK);
      if (uart_tx === 1'b0) begin
        t0 = cyc; r0 = rst_cnt; ok = 1'b1; aborted = 1'b0; seg = '0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge CLK);
          if (rst_cnt != r0) begin aborted = 1'b1; break; end
          if (i % DIV == 0) seg[i/DIV] = uart_tx;
          else if (uart_tx !== seg[i/DIV]) ok = 1'b0;
        end
        if (!aborted) begin
          if (seg[0] !== 1'b0 || seg[9] !== 1'b1) ok = 1'b0;
          rx_q.push_back(seg[8:1]);
          rx_t.push_back(t0);
          rx_ok.push_back(ok);
        end
      end
    end
  end

  // Present a byte and hold wr_valid until accepted; acc = edge number of acceptance or -1.
  task automatic push_wait(input logic [7:0] b, input int max, output int acc);
    bit rdy;
    acc = -1;
    wr_valid = 1'b1;
    wr_data  = b;
    for (int i = 0; i < max; i++) begin
      rdy = (wr_ready === 1'b1);
      @(negedge CLK);
      if (rdy) begin acc = cyc; exp_q.push_back(b); break; end
    end
  endtask

  task automatic wait_rx(input int n, input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rx_q.size() >= n) begin got = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic wait_idle(output bit got);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (tx_busy === 1'b0 && fifo_level === 3'd0) begin got = 1'b1; break; end
      @(negedge CLK);
    end
    repeat (2) @(negedge CLK);
    exp_q.delete(); rx_q.delete(); rx_t.delete(); rx_ok.delete();
  endtask

  task automatic test_reset;
    int bad;
    RSTb = 1'b0; wr_valid = 1'b1; wr_data = 8'($urandom);
    repeat (3) @(negedge CLK);
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    RSTb = 1'b1; wr_valid = 1'b0;
    @(negedge CLK);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    bad = 0;
    repeat (40) begin
      @(negedge CLK);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL reset_no_frame bad_cycles=%0d exp=0", bad); end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL reset_rx_count got=%0d exp=0", rx_q.size()); end
    $display("test_reset done");
  endtask

  task automatic test_single(input logic [7:0] b);
    int n; bit got; logic [9:0] fbits; logic e;
    wait_idle(got);
    checks++; if (!got) begin failures++; $display("FAIL single_idle_timeout got=0 exp=1"); end
    fbits = {1'b1, b, 1'b0};
    push_wait(b, 4, n);
    wr_valid = 1'b0;
    checks++; if (n < 0) begin failures++; $display("FAIL single_accept got=%0d exp=accepted", n); end
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL single_level_push got=%0d exp=1", fifo_level); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_push got=%b exp=0", tx_busy); end
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge CLK);
      e = fbits[(k-1)/DIV];
      checks++;
      if (uart_tx !== e || tx_busy !== 1'b1) begin
        failures++;
        $display("FAIL single_line cyc=N+%0d got tx=%b busy=%b exp tx=%b busy=1", k, uart_tx, tx_busy, e);
      end
      if (k == 1) begin
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL single_level_pop got=%0d exp=0", fifo_level); end
      end
    end
    @(negedge CLK);
    checks++; if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin failures++; $display("FAIL single_end got busy=%b tx=%b exp busy=0 tx=1", tx_busy, uart_tx); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== b || !rx_ok[0]) begin failures++; $display("FAIL single_decode got=%h exp=%h", rx_q.size() > 0 ? rx_q[0] : 8'hxx, b); end
    $display("test_single byte=%h done", b);
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
    int n1, n2; bit got;
    wait_idle(got);
    checks++; if (!got) begin failures++; $display("FAIL b2b_idle_timeout got=0 exp=1"); end
    push_wait(a, 4, n1);
    push_wait(b, 4, n2);
    wr_valid = 1'b0;
    checks++; if (n2 != n1 + 1) begin failures++; $display("FAIL b2b_accept got=%0d exp=%0d", n2, n1 + 1); end
    wait_rx(2, 400, got);
    checks++; if (!got) begin failures++; $display("FAIL b2b_timeout frames=%0d exp=2", rx_q.size()); end
    if (got) begin
      checks++; if (rx_t[0] != n1 + 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", rx_t[0], n1 + 1); end
      checks++; if (rx_t[1] - rx_t[0] != FRAME) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", rx_t[1] - rx_t[0], FRAME); end
      for (int i = 0; i < 2; i++) begin
        checks++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h ok=%0d exp=%h", i, rx_q[i], rx_ok[i], exp_q[i]); end
      end
    end
    $display("test_back_to_back %h %h done", a, b);
  endtask

  task automatic test_full;
    int acc[6]; bit got; logic [7:0] b;
    wait_idle(got);
    checks++; if (!got) begin failures++; $display("FAIL full_idle_timeout got=0 exp=1"); end
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      push_wait(b, 200, acc[i]);
      if (i == 4) begin
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready got=%b exp=0", wr_ready); end
      end
    end
    wr_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      checks++; if (acc[i] != acc[0] + i) begin failures++; $display("FAIL full_accept%0d got=%0d exp=%0d", i, acc[i], acc[0] + i); end
    end
    checks++; if (acc[5] != acc[0] + FRAME + 2) begin failures++; $display("FAIL full_sixth_accept got=%0d exp=%0d", acc[5], acc[0] + FRAME + 2); end
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_level_refill got=%0d exp=4", fifo_level); end
    wait_rx(6, 900, got);
    checks++; if (!got) begin failures++; $display("FAIL full_timeout frames=%0d exp=6", rx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin failures++; $display("FAIL full_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    $display("test_full done");
  endtask

  task automatic test_same_edge;
    int a0, a1, a2, a3; bit got;
    wait_idle(got);
    checks++; if (!got) begin failures++; $display("FAIL same_idle_timeout got=0 exp=1"); end
    push_wait(8'($urandom), 4, a0);
    push_wait(8'($urandom), 4, a1);
    push_wait(8'($urandom), 4, a2);
    wr_valid = 1'b0;
    checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL same_level_before got=%0d exp=2", fifo_level); end
    for (int i = 0; i < 200 && cyc < a0 + FRAME; i++) @(negedge CLK);
    push_wait(8'($urandom), 1, a3);
    wr_valid = 1'b0;
    checks++; if (a3 != a0 + FRAME + 1) begin failures++; $display("FAIL same_accept got=%0d exp=%0d", a3, a0 + FRAME + 1); end
    checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL same_level_after got=%0d exp=2", fifo_level); end
    checks++; if (uart_tx !== 1'b0) begin failures++; $display("FAIL same_restart got=%b exp=0", uart_tx); end
    wait_rx(4, 500, got);
    checks++; if (!got) begin failures++; $display("FAIL same_timeout frames=%0d exp=4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin failures++; $display("FAIL same_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    $display("test_same_edge done");
  endtask

  task automatic test_reset_mid;
    int a0, a1, az; bit got; logic [7:0] y0, z;
    wait_idle(got);
    checks++; if (!got) begin failures++; $display("FAIL mid_idle_timeout got=0 exp=1"); end
    y0 = 8'($urandom);
    push_wait(y0, 4, a0);
    push_wait(8'($urandom), 4, a1);
    wr_valid = 1'b0;
    for (int i = 0; i < 100 && cyc < a0 + 44; i++) @(negedge CLK);
    checks++; if (uart_tx !== y0[3]) begin failures++; $display("FAIL mid_bit3 got=%b exp=%b", uart_tx, y0[3]); end
    RSTb = 1'b0;
    @(negedge CLK);
    RSTb = 1'b1;
    checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL mid_uart_tx got=%b exp=1", uart_tx); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL mid_level got=%0d exp=0", fifo_level); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", tx_busy); end
    repeat (30) @(negedge CLK);
    checks++; if (rx_q.size() != 0 || uart_tx !== 1'b1) begin failures++; $display("FAIL mid_no_resend frames=%0d tx=%b exp frames=0 tx=1", rx_q.size(), uart_tx); end
    exp_q.delete();
    z = 8'($urandom);
    push_wait(z, 4, az);
    wr_valid = 1'b0;
    wait_rx(1, 200, got);
    repeat (20) @(negedge CLK);
    checks++; if (!got || rx_q.size() != 1 || rx_q[0] !== z || !rx_ok[0]) begin failures++; $display("FAIL mid_fresh frames=%0d got=%h exp=%h", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx, z); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random;
    int acc; bit got;
    wait_idle(got);
    checks++; if (!got) begin failures++; $display("FAIL rand_idle_timeout got=0 exp=1"); end
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 120)) @(negedge CLK);
      push_wait(8'($urandom), 400, acc);
      wr_valid = 1'b0;
      checks++; if (acc < 0) begin failures++; $display("FAIL rand_accept%0d got=timeout exp=accepted", i); end
    end
    wait_rx(10, 1500, got);
    checks++; if (!got) begin failures++; $display("FAIL rand_timeout frames=%0d exp=10", rx_q.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_single(8'h55);
    test_single(8'($urandom));
    test_back_to_back(8'hA3, 8'h0F);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_full();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
